// File: rtl/encrip_arbiter.sv
// encrip_arbiter: round-robin sharing of a fixed 3-to-5-bit code table between two symbol sources.
// Optional ENCRIP_KEY_EN adds a key input whose rotating register is XORed into every code.
module encrip_arbiter #(
   parameter int MAX_BURST = 8,
   parameter int CW        = 8
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic [1:0] req_valid,
   input  logic [2:0] req_data0,
   input  logic [2:0] req_data1,
   input  logic [1:0] req_last,
   output logic [1:0] req_ready,
   output logic       out_valid,
   output logic [4:0] out_code,
   output logic       out_src,
   output logic       out_last,
   input  logic       out_ready,
`ifdef ENCRIP_KEY_EN
   input  logic [4:0] key,
`endif
   output logic       busy,
   output logic       grant,
   output logic       err_trunc
);
   typedef enum logic {IDLE, SERVE} state_t;
   localparam logic [4:0]    TBL [8]  = '{5'd6, 5'd5, 5'd10, 5'd16, 5'd1, 5'd8, 5'd11, 5'd20};
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);
   state_t        state_q, state_d;
   logic          grant_q, grant_d, prio_q, prio_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_valid_q, out_valid_d, out_src_q, out_src_d, out_last_q, out_last_d;
   logic [4:0]    out_code_q, out_code_d;
   logic          err_q, err_d;
   logic          ld_ok, acc, lst, fin, start;
   logic [2:0]    sym;
   logic [4:0]    kx;
`ifdef ENCRIP_KEY_EN
   logic [4:0]    key_q, key_d;
   assign kx = key_q;
   assign key_d = start ? key : (acc ? {key_q[3:0], key_q[4]} : key_q);
`else
   assign kx = 5'd0;
`endif
   always_comb begin
      ld_ok       = !out_valid_q || out_ready;
      sym         = grant_q ? req_data1 : req_data0;
      lst         = req_last[grant_q];
      fin         = lst || (cnt_q == LAST_CNT);
      start       = (state_q == IDLE) && (req_valid != 2'b00);
      acc         = (state_q == SERVE) && req_valid[grant_q] && ld_ok;
      req_ready   = (state_q == SERVE && ld_ok) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
      state_d     = state_q;
      grant_d     = grant_q;
      prio_d      = prio_q;
      cnt_d       = cnt_q;
      out_valid_d = acc ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
      out_code_d  = acc ? (TBL[sym] ^ kx) : out_code_q;
      out_src_d   = acc ? grant_q : out_src_q;
      out_last_d  = acc ? fin : out_last_q;
      err_d       = acc && fin && !lst;
      if (start) begin
         state_d = SERVE;
         grant_d = (&req_valid) ? prio_q : req_valid[1];
      end
      if (acc) begin
         cnt_d = fin ? '0 : cnt_q + 1'b1;
         if (fin) begin
            state_d = IDLE;
            prio_d  = !grant_q;
         end
      end
   end
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         prio_q      <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_code_q  <= 5'd0;
         out_src_q   <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
`ifdef ENCRIP_KEY_EN
         key_q       <= 5'd0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         prio_q      <= prio_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_code_q  <= out_code_d;
         out_src_q   <= out_src_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
`ifdef ENCRIP_KEY_EN
         key_q       <= key_d;
`endif
      end
   end
   assign out_valid = out_valid_q;
   assign out_code  = out_code_q;
   assign out_src   = out_src_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == SERVE);
   assign grant     = grant_q;
   assign err_trunc = err_q;
endmodule

// File: tb/tb_encrip_arbiter.sv
// tb_encrip_arbiter: vector table feeding per-requester queues, scoreboard checked at the output handshake.
module tb_encrip_arbiter;
   logic       CLK = 1'b0, nRST = 1'b0;
   logic [1:0] req_valid = 2'b00, req_last = 2'b00, req_ready;
   logic [2:0] req_data0 = 3'd0, req_data1 = 3'd0;
   logic       out_valid, out_src, out_last, out_ready = 1'b1;
   logic [4:0] out_code;
   logic       busy, grant, err_trunc;
`ifdef ENCRIP_KEY_EN
   logic [4:0] key = 5'd0;
`endif
   encrip_arbiter dut (
      .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
      .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid), .out_code(out_code),
      .out_src(out_src), .out_last(out_last), .out_ready(out_ready),
`ifdef ENCRIP_KEY_EN
      .key(key),
`endif
      .busy(busy), .grant(grant), .err_trunc(err_trunc)
   );
   always #5 CLK = ~CLK;

   typedef struct {
      int         grp;
      logic       r;
      logic [2:0] sym;
      logic       lst;
      logic [4:0] code;
      logic       olast;
   } vec_t;
   vec_t vecs[$];
   vec_t q0[$], q1[$], sb[$];
   int checks = 0, errors = 0, err_cnt = 0, cyc;
   logic [63:0] stall = '0;
   logic pv = 1'b0, pr = 1'b0, ps = 1'b0, pl = 1'b0;
   logic [4:0] pc = 5'd0;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   function automatic void v(input int g, input logic r, input logic [2:0] s, input logic l,
                             input logic [4:0] c, input logic ol);
      vec_t t;
      t.grp = g; t.r = r; t.sym = s; t.lst = l; t.code = c; t.olast = ol;
      vecs.push_back(t);
   endfunction

   function automatic void load(input int g);
      foreach (vecs[i])
         if (vecs[i].grp == g) begin
            if (vecs[i].r) q1.push_back(vecs[i]);
            else q0.push_back(vecs[i]);
         end
   endfunction

   task automatic do_reset();
      nRST = 1'b0; req_valid = 2'b00; out_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      q0.delete(); q1.delete(); sb.delete();
      nRST = 1'b1;
   endtask

   task automatic drive(input int budget, input bit must, output int n);
      bit a0, a1;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
         req_valid = {q1.size() != 0, q0.size() != 0};
         req_data0 = q0.size() != 0 ? q0[0].sym : 3'd0;
         req_data1 = q1.size() != 0 ? q1[0].sym : 3'd0;
         req_last  = {q1.size() != 0 ? q1[0].lst : 1'b0, q0.size() != 0 ? q0[0].lst : 1'b0};
         out_ready = !stall[n];
         @(negedge CLK);
         if (!busy) chk("idle_ready", {30'd0, req_ready}, 0);
         if (out_valid && !out_ready) chk("stall_ready", {30'd0, req_ready}, 0);
         a0 = req_valid[0] && req_ready[0];
         a1 = req_valid[1] && req_ready[1];
         @(posedge CLK);
         #1;
         if (a0) begin sb.push_back(q0[0]); void'(q0.pop_front()); end
         if (a1) begin sb.push_back(q1[0]); void'(q1.pop_front()); end
         n++;
      end
      req_valid = 2'b00; req_last = 2'b00; out_ready = 1'b1;
      if (must) chk("drive_done", q0.size() + q1.size(), 0);
   endtask

   task automatic drain(input int budget);
      for (int c = 0; c < budget && sb.size() != 0; c++) begin
         @(posedge CLK);
         #1;
      end
      chk("drain", sb.size(), 0);
   endtask

   always @(negedge CLK) begin
      if (!nRST) pv = 1'b0;
      else begin
         if (pv && !pr) begin
            chk("stall_valid", {31'd0, out_valid}, 1);
            chk("stall_code", {27'd0, out_code}, {27'd0, pc});
            chk("stall_src", {31'd0, out_src}, {31'd0, ps});
            chk("stall_last", {31'd0, out_last}, {31'd0, pl});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", {27'd0, out_code}, 32'hFFFF_FFFF);
            else begin
               chk("out_code", {27'd0, out_code}, {27'd0, sb[0].code});
               chk("out_src", {31'd0, out_src}, {31'd0, sb[0].r});
               chk("out_last", {31'd0, out_last}, {31'd0, sb[0].olast});
               void'(sb.pop_front());
            end
         end
         if (err_trunc) err_cnt++;
         pv = out_valid; pr = out_ready; pc = out_code; ps = out_src; pl = out_last;
      end
   end

   initial begin
      v(1, 0, 0, 0, 6, 0); v(1, 0, 1, 0, 5, 0); v(1, 0, 2, 0, 10, 0); v(1, 0, 3, 1, 16, 1);
      v(2, 0, 4, 0, 1, 0); v(2, 0, 5, 1, 8, 1); v(2, 1, 6, 0, 11, 0); v(2, 1, 7, 1, 20, 1);
      v(3, 0, 1, 0, 5, 0); v(3, 0, 2, 0, 10, 0); v(3, 0, 3, 0, 16, 0); v(3, 0, 4, 1, 1, 1);
      v(4, 1, 7, 0, 20, 0); v(4, 1, 6, 0, 11, 0); v(4, 1, 5, 0, 8, 0); v(4, 1, 4, 0, 1, 0);
      v(4, 1, 3, 0, 16, 0); v(4, 1, 2, 0, 10, 0); v(4, 1, 1, 0, 5, 0); v(4, 1, 0, 0, 6, 1);
      v(4, 1, 1, 0, 5, 0); v(4, 1, 2, 0, 10, 0);
      v(5, 0, 1, 0, 5, 0); v(5, 0, 2, 0, 10, 0); v(5, 0, 3, 0, 16, 0); v(5, 0, 4, 0, 1, 0);
      v(6, 0, 3, 1, 16, 1); v(6, 1, 0, 1, 6, 1);
      v(7, 0, 0, 0, 7, 0); v(7, 0, 0, 1, 4, 1);

      do_reset();
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_code", {27'd0, out_code}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_grant", {31'd0, grant}, 0);
      chk("rst_err", {31'd0, err_trunc}, 0);

      load(1);
      drive(20, 1, cyc);
      chk("burst_cycles", cyc, 5);
      drain(10);
      chk("idle_after_last", {31'd0, busy}, 0);
      chk("no_trunc_real_last", err_cnt, 0);

      do_reset();
      load(2);
      drive(20, 1, cyc);
      load(6);
      drive(20, 1, cyc);
      drain(10);

      do_reset();
      load(3);
      stall = 64'h38;
      drive(30, 1, cyc);
      stall = '0;
      drain(10);

      do_reset();
      err_cnt = 0;
      load(4);
      drive(40, 1, cyc);
      drain(10);
      chk("trunc_pulses", err_cnt, 1);
      chk("regrant_req1", {31'd0, grant}, 1);

      do_reset();
      load(5);
      drive(3, 0, cyc);
      chk("pre_rst_valid", {31'd0, out_valid}, 1);
      nRST = 1'b0;
      @(posedge CLK);
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 0);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_grant", {31'd0, grant}, 0);
      chk("mid_rst_last", {31'd0, out_last}, 0);
      do_reset();
      load(6);
      drive(20, 1, cyc);
      drain(10);

`ifdef ENCRIP_KEY_EN
      do_reset();
      key = 5'b00001;
      load(7);
      drive(20, 1, cyc);
      key = 5'd0;
      drain(10);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
